stack_ram_ctrl: RTL and testbench

- Memory-side responder for the stack CPU RAM interface.
- 32-word x N register-file RAM:
  - Serves CPU reads and writes (program, data and stack share one space).
  - Host loader streams a program/data image in before execution.
  - Host dump streams all 32 words out afterwards.
- Sequencer FSM owns the RAM port and the cpu_en line; the CPU only runs in RUN.

---
 rtl/stack_ram_ctrl_pkg.sv | 21 ++
 rtl/ram_32xn.sv | 34 +++
 rtl/stack_ram_ctrl.sv | 142 ++++++++++++++
 tb/tb_stack_ram_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_ram_ctrl_pkg.sv
// Shared definitions for the stack CPU memory side: sequencer states and opcodes.
// Opcodes live here so the CPU and benches agree on one encoding.
package stack_ram_ctrl_pkg;

  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 5'd31;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_IDLE = 2'd1,
    S_RUN  = 2'd2,
    S_DUMP = 2'd3
  } state_t;

  localparam logic [2:0] PUSH = 3'd0;
  localparam logic [2:0] POP  = 3'd1;
  localparam logic [2:0] ADD  = 3'd2;
  localparam logic [2:0] SUB  = 3'd3;
  localparam logic [2:0] MULT = 3'd4;

endpackage

// File: rtl/ram_32xn.sv
// Register-file RAM: one write port, one enabled registered read port.
// A read of the address written in the same cycle returns the new data.
module ram_32xn
  import stack_ram_ctrl_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [N-1:0]      wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [N-1:0]      rdata
);

  logic [N-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset so images survive a reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/stack_ram_ctrl.sv
// Memory-side responder for the stack CPU: load image, run CPU, dump all words.
// One RAM port shared by loader, CPU and dump, arbitrated purely by sequencer state.
module stack_ram_ctrl
  import stack_ram_ctrl_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ram_w,
  input  logic [ADDR_W-1:0] ram_waddr,
  input  logic [N-1:0]      ram_wdata,
  input  logic [ADDR_W-1:0] ram_raddr,
  output logic [N-1:0]      ram_rdata,
  output logic              cpu_en,
  input  logic              load_valid,
  input  logic [N-1:0]      load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              start,
  input  logic              halt,
  output logic              dump_valid,
  output logic [N-1:0]      dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  input  logic              dump_ready,
  output logic              busy
);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              cpu_owns;
  logic [N-1:0]      cpu_hold;
  logic [N-1:0]      ram_q;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [N-1:0]      wdata;
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic              load_acc;

  assign load_acc = (state == S_LOAD) && load_valid && load_ready;

  assign we    = load_acc || ((state == S_RUN) && ram_w);
  assign waddr = (state == S_LOAD) ? ptr : ram_waddr;
  assign wdata = (state == S_LOAD) ? load_data : ram_wdata;

  // Dump prefetches the next word on each transfer so the stream has no bubbles.
  assign re    = (state == S_RUN) ||
                 ((state == S_DUMP) &&
                  (!dump_valid || (dump_ready && (dump_addr != LAST_ADDR))));
  assign raddr = (state == S_RUN) ? ram_raddr :
                 (dump_valid ? dump_addr + 5'd1 : '0);

  // The read register is reused by dump; cpu_hold keeps the CPU's last word visible.
  assign ram_rdata = cpu_owns ? ram_q : cpu_hold;
  assign dump_data = cpu_owns ? '0 : ram_q;

  ram_32xn #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_LOAD;
      ptr        <= '0;
      cpu_en     <= 1'b0;
      load_ready <= 1'b0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      busy       <= 1'b0;
      cpu_owns   <= 1'b1;
      cpu_hold   <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          busy       <= 1'b1;
          load_ready <= 1'b1;
          if (load_acc) begin
            if (load_last || (ptr == LAST_ADDR)) begin
              state      <= S_IDLE;
              ptr        <= '0;
              load_ready <= 1'b0;
              busy       <= 1'b0;
            end else begin
              ptr <= ptr + 5'd1;
            end
          end
        end
        S_IDLE: begin
          if (start) begin
            state  <= S_RUN;
            cpu_en <= 1'b1;
            busy   <= 1'b1;
          end
        end
        S_RUN: begin
          cpu_owns <= 1'b1;
          if (halt) begin
            state      <= S_DUMP;
            cpu_en     <= 1'b0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
          end
        end
        S_DUMP: begin
          if (cpu_owns) begin
            cpu_hold <= ram_q;
            cpu_owns <= 1'b0;
          end
          if (!dump_valid) begin
            dump_valid <= 1'b1;
            dump_addr  <= '0;
          end else if (dump_ready) begin
            if (dump_addr == LAST_ADDR) begin
              dump_valid <= 1'b0;
              dump_addr  <= '0;
              ptr        <= '0;
              state      <= S_LOAD;
              load_ready <= 1'b1;
            end else begin
              dump_addr <= dump_addr + 5'd1;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ram_ctrl.sv
// Directed bench for stack_ram_ctrl: vector table for load/run, hand sequences for dump and reset.
module tb_stack_ram_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ram_w;
  logic [4:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic [4:0] ram_raddr;
  logic [7:0] ram_rdata;
  logic       cpu_en;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       start;
  logic       halt;
  logic       dump_valid;
  logic [7:0] dump_data;
  logic [4:0] dump_addr;
  logic       dump_ready;
  logic       busy;

  int tests = 0;
  int fails = 0;
  logic [7:0] got [32];

  stack_ram_ctrl #(.N(8), .DEPTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .ram_w      (ram_w),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_raddr  (ram_raddr),
    .ram_rdata  (ram_rdata),
    .cpu_en     (cpu_en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .start      (start),
    .halt       (halt),
    .dump_valid (dump_valid),
    .dump_data  (dump_data),
    .dump_addr  (dump_addr),
    .dump_ready (dump_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       lv;
    logic [7:0] ld;
    logic       ll;
    logic       st;
    logic       ht;
    logic       w;
    logic [4:0] wa;
    logic [7:0] wd;
    logic [4:0] ra;
    logic       e_lr;
    logic       e_busy;
    logic       e_en;
    logic       c_rd;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_dump(input logic [3:0] ready_pat, input int stop_at, output int n_xfer);
    logic       pv;
    logic [4:0] pa;
    logic [7:0] pd;
    int         k;
    k = 0;
    n_xfer = 0;
    for (int cyc = 0; cyc < 300 && n_xfer < 32; cyc++) begin
      if (stop_at >= 0 && dump_valid && dump_addr == 5'(stop_at)) break;
      dump_ready = ready_pat[k % 4];
      k++;
      pv = dump_valid;
      pa = dump_addr;
      pd = dump_data;
      tick();
      if (pv && dump_ready) begin
        chk("dump.order", 32'(pa), 32'(n_xfer));
        got[pa] = pd;
        n_xfer++;
      end else if (pv) begin
        chk("dump.hold_addr", 32'(dump_addr), 32'(pa));
        chk("dump.hold_data", 32'(dump_data), 32'(pd));
      end
    end
    dump_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int acc;
    logic pr;
    logic [7:0] e;

    //            lv  ld     ll  st  ht  w   wa     wd     ra     lr  bsy en  crd rd
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  8'h00, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  8'h00, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  8'h00, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  8'h00, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  8'hEE, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  8'h00, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 8'hAA, 5'd31, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  8'h00, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h02};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  8'h00, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 8'h05};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  8'h7F, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2,  8'hEE, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03};

    reset = 1'b0;
    ram_w = 0; ram_waddr = 0; ram_wdata = 0; ram_raddr = 0;
    load_valid = 0; load_data = 0; load_last = 0;
    start = 0; halt = 0; dump_ready = 0;

    #2;
    chk("reset.load_ready", 32'(load_ready), 0);
    chk("reset.busy",       32'(busy), 0);
    chk("reset.cpu_en",     32'(cpu_en), 0);
    chk("reset.dump_valid", 32'(dump_valid), 0);
    chk("reset.ram_rdata",  32'(ram_rdata), 0);
    chk("reset.dump_data",  32'(dump_data), 0);
    @(negedge clk);
    reset = 1'b1;

    // Load 4 words, ignored IDLE traffic, run with bypass read, halt with a write.
    for (int i = 0; i < 12; i++) begin
      load_valid = vecs[i].lv; load_data = vecs[i].ld; load_last = vecs[i].ll;
      start = vecs[i].st; halt = vecs[i].ht;
      ram_w = vecs[i].w; ram_waddr = vecs[i].wa; ram_wdata = vecs[i].wd; ram_raddr = vecs[i].ra;
      tick();
      chk($sformatf("vec%0d.load_ready", i), 32'(load_ready), 32'(vecs[i].e_lr));
      chk($sformatf("vec%0d.busy", i),       32'(busy),       32'(vecs[i].e_busy));
      chk($sformatf("vec%0d.cpu_en", i),     32'(cpu_en),     32'(vecs[i].e_en));
      if (vecs[i].c_rd)
        chk($sformatf("vec%0d.ram_rdata", i), 32'(ram_rdata), 32'(vecs[i].e_rd));
    end
    load_valid = 0; load_last = 0; start = 0; halt = 0; ram_w = 0;

    // Full dump with a 1,0,0,1 ready pattern.
    run_dump(4'b1001, -1, n);
    chk("dump1.count",      32'(n), 32);
    chk("dump1.load_ready", 32'(load_ready), 1);
    chk("dump1.valid_low",  32'(dump_valid), 0);
    chk("dump1.ram_rdata_held", 32'(ram_rdata), 32'h03);
    chk("dump1.mem0",  32'(got[0]),  32'h02);
    chk("dump1.mem1",  32'(got[1]),  32'h03);
    chk("dump1.mem2",  32'(got[2]),  32'h04);
    chk("dump1.mem3",  32'(got[3]),  32'h05);
    chk("dump1.mem5",  32'(got[5]),  32'h7F);
    chk("dump1.mem31", 32'(got[31]), 32'hAA);

    // 32-word load without load_last must self-terminate.
    acc = 0;
    for (int c = 0; c < 40 && acc < 32; c++) begin
      load_valid = 1'b1;
      load_data  = 8'h40 + 8'(acc);
      pr = load_ready;
      tick();
      if (pr) acc++;
    end
    chk("load32.accepted",   32'(acc), 32);
    chk("load32.load_ready", 32'(load_ready), 0);
    chk("load32.busy",       32'(busy), 0);
    load_data = 8'hFF;
    tick();
    chk("load33.not_ready", 32'(load_ready), 0);
    load_valid = 1'b0;

    start = 1'b1; tick(); start = 1'b0;
    chk("run2.cpu_en", 32'(cpu_en), 1);
    halt = 1'b1; tick(); halt = 1'b0;
    chk("halt2.cpu_en", 32'(cpu_en), 0);

    // Abandon a dump at address 10 with an asynchronous reset.
    run_dump(4'b1111, 10, n);
    chk("dump2.partial_count", 32'(n), 10);
    acc = 0;
    for (int i = 0; i < 10; i++) if (got[i] !== 8'h40 + 8'(i)) acc++;
    chk("dump2.prefix_errors", 32'(acc), 0);
    chk("dump2.at_addr10", 32'(dump_addr), 10);
    #1 reset = 1'b0;
    #1;
    chk("midreset.dump_valid", 32'(dump_valid), 0);
    chk("midreset.dump_addr",  32'(dump_addr), 0);
    chk("midreset.dump_data",  32'(dump_data), 0);
    chk("midreset.ram_rdata",  32'(ram_rdata), 0);
    chk("midreset.busy",       32'(busy), 0);
    chk("midreset.load_ready", 32'(load_ready), 0);
    reset = 1'b1;

    tick();
    chk("reload.load_ready", 32'(load_ready), 1);
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 8'h11 + 8'(i);
      load_last  = (i == 2);
      tick();
    end
    load_valid = 0; load_last = 0;
    chk("reload.idle_busy", 32'(busy), 0);
    start = 1'b1; tick(); start = 1'b0;
    halt  = 1'b1; tick(); halt  = 1'b0;
    run_dump(4'b1001, -1, n);
    chk("dump3.count", 32'(n), 32);
    for (int i = 0; i < 32; i++) begin
      e = (i < 3) ? 8'h11 + 8'(i) : 8'h40 + 8'(i);
      chk($sformatf("dump3.mem%0d", i), 32'(got[i]), 32'(e));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
